// File: rtl/dm_stage.sv
// Data-memory stage: single-cycle local RAM plus an I/O window (addr[15:12]==4'hC) forwarded
// over a level req/rdy handshake. Define DM_IO_TIMEOUT_EN to enable the I/O access timeout.
module dm_stage #(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned IO_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_re_EX,
   input  logic        dm_we_EX,
   input  logic [15:0] dm_addr_EX,
   input  logic [15:0] dm_wrt_data_EX,
   output logic [15:0] dm_rd_data_EX_DM,
   output logic        stall_DM,
   output logic [11:0] io_addr,
   output logic [15:0] io_wdata,
   output logic        io_re,
   output logic        io_we,
   input  logic [15:0] io_rdata,
   input  logic        io_rdy,
   output logic        io_timeout_err
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e              state_q, state_d;
   logic [15:0]         mem [2**ADDR_W];
   logic [ADDR_W-1:0]   ram_idx;
   logic [15:0]         ram_rd_q;
   logic [15:0]         hold_q, hold_d;
   logic                sel_io_q;
   logic                io_re_q, io_re_d;
   logic                io_we_q, io_we_d;
   logic [11:0]         io_addr_q;
   logic [15:0]         io_wdata_q;
   logic                err_q, err_d;
   logic                accept, is_io, io_req, ram_we, ram_re;
   logic                timeout;

   // New requests are ignored while an I/O access is outstanding.
   assign accept  = (state_q != StReq) && (dm_re_EX || dm_we_EX);
   assign is_io   = (dm_addr_EX[15:12] == 4'hC);
   assign io_req  = accept && is_io;
   assign ram_we  = accept && !is_io && dm_we_EX && !rst;
   assign ram_re  = accept && !is_io && dm_re_EX;
   assign ram_idx = dm_addr_EX[ADDR_W-1:0];

`ifdef DM_IO_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;

   logic [CntW-1:0] cnt_q;

   // Held at zero outside REQ, so every REQ entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_q != StReq) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign timeout = (state_q == StReq) && (cnt_q == CntW'(IO_TIMEOUT - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^IO_TIMEOUT;
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      io_re_d = io_re_q;
      io_we_d = io_we_q;
      hold_d  = hold_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StResp: begin
            if (io_req) begin
               state_d = StReq;
               io_re_d = dm_re_EX && !dm_we_EX;
               io_we_d = dm_we_EX;
            end else begin
               state_d = StIdle;
            end
         end
         StReq: begin
            if (io_rdy) begin
               state_d = StResp;
               hold_d  = io_rdata;
               io_re_d = 1'b0;
               io_we_d = 1'b0;
            end else if (timeout) begin
               state_d = StResp;
               hold_d  = 16'hDEAD;
               io_re_d = 1'b0;
               io_we_d = 1'b0;
               err_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         io_re_q    <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= '0;
         io_wdata_q <= '0;
         hold_q     <= '0;
         ram_rd_q   <= '0;
         sel_io_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         io_re_q <= io_re_d;
         io_we_q <= io_we_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         if (io_req) begin
            io_addr_q  <= dm_addr_EX[11:0];
            io_wdata_q <= dm_wrt_data_EX;
         end
         // Read-first: a same-cycle write is not visible here.
         if (ram_re) begin
            ram_rd_q <= mem[ram_idx];
         end
         if (accept) begin
            sel_io_q <= is_io;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_idx] <= dm_wrt_data_EX;
      end
   end

   assign dm_rd_data_EX_DM = sel_io_q ? hold_q : ram_rd_q;
   assign stall_DM         = (state_q == StReq);
   assign io_addr          = io_addr_q;
   assign io_wdata         = io_wdata_q;
   assign io_re            = io_re_q;
   assign io_we            = io_we_q;
   assign io_timeout_err   = err_q;

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: RAM load/store, read-first collision, I/O handshake,
// back-to-back I/O, reset mid-access and (with DM_IO_TIMEOUT_EN) the I/O timeout.
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dm_re_EX = 1'b0;
   logic        dm_we_EX = 1'b0;
   logic [15:0] dm_addr_EX = '0;
   logic [15:0] dm_wrt_data_EX = '0;
   logic [15:0] dm_rd_data_EX_DM;
   logic        stall_DM;
   logic [11:0] io_addr;
   logic [15:0] io_wdata;
   logic        io_re;
   logic        io_we;
   logic [15:0] io_rdata = '0;
   logic        io_rdy = 1'b0;
   logic        io_timeout_err;

   int          total = 0;
   int          bad = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_v;

   dm_stage #(.ADDR_W(13), .IO_TIMEOUT(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .dm_re_EX         (dm_re_EX),
      .dm_we_EX         (dm_we_EX),
      .dm_addr_EX       (dm_addr_EX),
      .dm_wrt_data_EX   (dm_wrt_data_EX),
      .dm_rd_data_EX_DM (dm_rd_data_EX_DM),
      .stall_DM         (stall_DM),
      .io_addr          (io_addr),
      .io_wdata         (io_wdata),
      .io_re            (io_re),
      .io_we            (io_we),
      .io_rdata         (io_rdata),
      .io_rdy           (io_rdy),
      .io_timeout_err   (io_timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dm_re_EX = 1'b0;
      dm_we_EX = 1'b0;
      dm_addr_EX = '0;
      dm_wrt_data_EX = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      total++;
      if (stall_DM !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall_DM); end
      total++;
      if ({io_re, io_we} !== 2'b00) begin
         bad++; $display("FAIL reset_strobes: got %b expected 00", {io_re, io_we});
      end
      total++;
      if (io_addr !== 12'h000 || io_wdata !== 16'h0000) begin
         bad++; $display("FAIL reset_io_regs: got %h/%h expected 000/0000", io_addr, io_wdata);
      end
      total++;
      if (dm_rd_data_EX_DM !== 16'h0000) begin
         bad++; $display("FAIL reset_rd_data: got %h expected 0000", dm_rd_data_EX_DM);
      end
      total++;
      if (io_timeout_err !== 1'b0) begin
         bad++; $display("FAIL reset_err: got %b expected 0", io_timeout_err);
      end
   endtask

   task automatic test_ram_store_load();
      int stalls;
      stalls = 0;
      dm_we_EX = 1'b1; dm_addr_EX = 16'h0010; dm_wrt_data_EX = 16'h1234;
      step();
      if (stall_DM) stalls++;
      dm_we_EX = 1'b0; dm_re_EX = 1'b1; dm_addr_EX = 16'h0010;
      sb.push_back(16'h1234);
      step();
      if (stall_DM) stalls++;
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL ram_load: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      // 0x2010 aliases index 0x0010 with a 13-bit RAM index.
      dm_addr_EX = 16'h2010;
      sb.push_back(16'h1234);
      step();
      if (stall_DM) stalls++;
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL ram_alias: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      idle_inputs();
      total++;
      if (stalls != 0) begin bad++; $display("FAIL ram_no_stall: got %0d expected 0", stalls); end
   endtask

   task automatic test_rw_same();
      dm_we_EX = 1'b1; dm_addr_EX = 16'h0020; dm_wrt_data_EX = 16'hAAAA;
      step();
      dm_re_EX = 1'b1; dm_we_EX = 1'b1; dm_wrt_data_EX = 16'h5555;
      sb.push_back(16'hAAAA);
      step();
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL rw_read_first: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      dm_we_EX = 1'b0;
      sb.push_back(16'h5555);
      step();
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL rw_later_load: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      idle_inputs();
   endtask

   task automatic test_io_read();
      int stalls;
      int re_hi;
      stalls = 0;
      re_hi = 0;
      dm_re_EX = 1'b1; dm_addr_EX = 16'hC004; io_rdata = 16'hBEEF; io_rdy = 1'b0;
      sb.push_back(16'hBEEF);
      step();
      for (int i = 1; i <= 3; i++) begin
         if (stall_DM) stalls++;
         if (io_re) re_hi++;
         total++;
         if (io_addr !== 12'h004) begin
            bad++; $display("FAIL io_read_addr: got %h expected 004", io_addr);
         end
         io_rdy = (i == 3);
         step();
      end
      io_rdy = 1'b0;
      total++;
      if (stalls != 3 || re_hi != 3) begin
         bad++; $display("FAIL io_read_cycles: got stall=%0d re=%0d expected 3/3", stalls, re_hi);
      end
      total++;
      if (stall_DM !== 1'b0 || io_re !== 1'b0) begin
         bad++; $display("FAIL io_read_resp_ctl: got %b%b expected 00", stall_DM, io_re);
      end
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL io_read_data: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      // RAM load accepted in the RESP cycle switches the output back to RAM.
      dm_addr_EX = 16'h0010;
      sb.push_back(16'h1234);
      step();
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v || stall_DM !== 1'b0) begin
         bad++; $display("FAIL io_then_ram: got %h/%b expected %h/0", dm_rd_data_EX_DM, stall_DM,
                         exp_v);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [2];
      logic [15:0] datas [2];
      addrs[0] = 16'hC010; addrs[1] = 16'hC020;
      datas[0] = 16'h1111; datas[1] = 16'h2222;
      io_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         dm_we_EX = 1'b1; dm_addr_EX = addrs[k]; dm_wrt_data_EX = datas[k];
         step();
         total++;
         if (stall_DM !== 1'b1 || io_we !== 1'b1 || io_re !== 1'b0) begin
            bad++; $display("FAIL b2b_req%0d_ctl: got stall=%b we=%b re=%b expected 1/1/0", k,
                            stall_DM, io_we, io_re);
         end
         total++;
         if (io_addr !== addrs[k][11:0] || io_wdata !== datas[k]) begin
            bad++; $display("FAIL b2b_req%0d_regs: got %h/%h expected %h/%h", k, io_addr,
                            io_wdata, addrs[k][11:0], datas[k]);
         end
         step();
         total++;
         if (stall_DM !== 1'b0 || io_we !== 1'b0) begin
            bad++; $display("FAIL b2b_resp%0d: got stall=%b we=%b expected 0/0", k, stall_DM,
                            io_we);
         end
      end
      idle_inputs();
      io_rdy = 1'b0;
      step();
      total++;
      if (stall_DM !== 1'b0 || io_we !== 1'b0) begin
         bad++; $display("FAIL b2b_idle: got stall=%b we=%b expected 0/0", stall_DM, io_we);
      end
   endtask

   task automatic test_reset_mid_req();
      dm_re_EX = 1'b1; dm_addr_EX = 16'hC008; io_rdy = 1'b0; io_rdata = 16'h7777;
      step();
      step();
      total++;
      if (stall_DM !== 1'b1 || io_re !== 1'b1) begin
         bad++; $display("FAIL midreq_pre: got stall=%b re=%b expected 1/1", stall_DM, io_re);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      total++;
      if (stall_DM !== 1'b0 || io_re !== 1'b0 || io_we !== 1'b0) begin
         bad++; $display("FAIL midreq_reset: got stall=%b re=%b we=%b expected 0/0/0", stall_DM,
                         io_re, io_we);
      end
      io_rdy = 1'b1;
      step();
      io_rdy = 1'b0;
      step();
      total++;
      if (stall_DM !== 1'b0 || io_re !== 1'b0 || dm_rd_data_EX_DM !== 16'h0000) begin
         bad++; $display("FAIL midreq_late_rdy: got stall=%b re=%b data=%h expected 0/0/0000",
                         stall_DM, io_re, dm_rd_data_EX_DM);
      end
   endtask

`ifdef DM_IO_TIMEOUT_EN
   task automatic test_timeout();
      int stalls;
      stalls = 0;
      dm_re_EX = 1'b1; dm_addr_EX = 16'hC00C; io_rdy = 1'b0;
      sb.push_back(16'hDEAD);
      step();
      for (int i = 0; i < 8 && stall_DM === 1'b1; i++) begin
         stalls++;
         step();
      end
      dm_re_EX = 1'b0;
      total++;
      if (stalls != 4) begin bad++; $display("FAIL timeout_stalls: got %0d expected 4", stalls); end
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v) begin
         bad++; $display("FAIL timeout_data: got %h expected %h", dm_rd_data_EX_DM, exp_v);
      end
      step();
      step();
      total++;
      if (io_timeout_err !== 1'b1 || io_re !== 1'b0) begin
         bad++; $display("FAIL timeout_err_sticky: got err=%b re=%b expected 1/0",
                         io_timeout_err, io_re);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (io_timeout_err !== 1'b0) begin
         bad++; $display("FAIL timeout_err_clear: got %b expected 0", io_timeout_err);
      end
   endtask
`else
   task automatic test_no_timeout();
      int stalls;
      stalls = 0;
      dm_re_EX = 1'b1; dm_addr_EX = 16'hC00C; io_rdy = 1'b0; io_rdata = 16'h4321;
      sb.push_back(16'h4321);
      step();
      for (int i = 0; i < 300; i++) begin
         if (stall_DM) stalls++;
         step();
      end
      total++;
      if (stalls != 300 || io_timeout_err !== 1'b0) begin
         bad++; $display("FAIL no_timeout_wait: got stall=%0d err=%b expected 300/0", stalls,
                         io_timeout_err);
      end
      io_rdy = 1'b1;
      step();
      io_rdy = 1'b0;
      dm_re_EX = 1'b0;
      exp_v = sb.pop_front();
      total++;
      if (dm_rd_data_EX_DM !== exp_v || stall_DM !== 1'b0) begin
         bad++; $display("FAIL no_timeout_resp: got %h/%b expected %h/0", dm_rd_data_EX_DM,
                         stall_DM, exp_v);
      end
      idle_inputs();
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_ram_store_load();
      test_rw_same();
      test_io_read();
      test_back_to_back();
      test_reset_mid_req();
`ifdef DM_IO_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_stage.md
# dm_stage

Data-memory stage of the pipelined CPU, sitting between the EX stage and the destination-select flop that feeds register-file write-back. It services loads and stores from a local synchronous RAM with single-cycle latency. Addresses in the I/O window are forwarded over a level req/rdy handshake to the peripheral bus, stalling the pipeline until the peripheral responds. The read result is presented as `dm_rd_data_EX_DM`, valid throughout the EX_DM cycle.

## Interface

Parameters:
- `ADDR_W`, default 13: RAM index width; the RAM holds 2^ADDR_W 16-bit words.
- `IO_TIMEOUT`, default 255: cycles to wait for `io_rdy` before aborting an I/O access. Used only when DM_IO_TIMEOUT_EN is defined.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `dm_re_EX` input 1: the EX-stage instruction is a load.
- `dm_we_EX` input 1: the EX-stage instruction is a store.
- `dm_addr_EX` input 16: ALU-computed effective address.
- `dm_wrt_data_EX` input 16: store data.
- `dm_rd_data_EX_DM` output 16: load result for the EX_DM cycle.
- `stall_DM` output 1: freezes the PC and all pipeline registers at the next edge.
- `io_addr` output 12: peripheral register address.
- `io_wdata` output 16: peripheral write data.
- `io_re` output 1: peripheral read strobe.
- `io_we` output 1: peripheral write strobe.
- `io_rdata` input 16: peripheral read data.
- `io_rdy` input 1: peripheral completion.
- `io_timeout_err` output 1: sticky flag set when an I/O access times out.

## Operation

- **Decode:** `dm_addr_EX[15:12]==4'hC` selects I/O. Any other value selects RAM at index `dm_addr_EX[ADDR_W-1:0]`; upper bits are ignored, so aliasing wraps.
- **Simultaneous `dm_re_EX` and `dm_we_EX`:**
  - The write wins and the read is ignored.
  - The read data returned is the pre-write RAM word.
- **Request acceptance:** a request is accepted at a posedge when `stall_DM==0`.
- **RAM access:**
  - Writes take effect at the accepting edge.
  - Reads latch the word into the output register at that same edge. The read is read-first: a read never observes a write issued in the same cycle.
- **I/O FSM states: IDLE, REQ, RESP.**
  - IDLE→REQ when an I/O request is accepted. At that edge, register `io_addr=dm_addr_EX[11:0]` and `io_wdata`, and set `io_re`/`io_we`.
  - In REQ, the strobes stay high (level handshake) until `io_rdy` is sampled high. At that edge:
    - capture `io_rdata` into the hold register;
    - clear the strobes;
    - go to RESP.
  - In RESP, present the hold register on `dm_rd_data_EX_DM` and drive `stall_DM=0`. The next state is REQ if a new I/O request is accepted, otherwise IDLE.
  - For an I/O write, the hold register content is don't-care.
- **`stall_DM`:** equals `(state==REQ)`, decoded from registered state with no combinational path from `io_rdy`. The upstream stage holds all `*_EX` inputs stable while stalled, and new requests are ignored in REQ.
- **Output mux:** a registered source-select flop picks the RAM read register or the I/O hold register, according to the last accepted access.
- **Reset values:**
  - state IDLE;
  - `io_re`, `io_we`, `stall_DM`, `io_timeout_err` = 0;
  - `io_addr`, `io_wdata`, `dm_rd_data_EX_DM` = 0;
  - RAM contents are not reset.
- **Reset mid-REQ:** the strobes drop at the reset edge and the access is abandoned. A late `io_rdy` is ignored.

## Timing

- RAM load: 0 stall cycles. Data is valid for the whole cycle following the accepting edge.
- I/O access with `io_rdy` seen N cycles after REQ entry (N≥1): `stall_DM` is high for N cycles, and data is valid in the RESP cycle.
- Minimum I/O overhead is 1 stall cycle, when `io_rdy` is high in the first REQ cycle.
- Back-to-back I/O accesses: RESP→REQ directly, with no idle cycle.

## Configuration

- **`DM_IO_TIMEOUT_EN` defined:**
  - An 8+ bit counter clears on REQ entry and increments each REQ cycle.
  - When it reaches `IO_TIMEOUT` with no `io_rdy`, the FSM drops the strobes, loads 16'hDEAD into the hold register, sets `io_timeout_err` (cleared only by `rst`), and goes to RESP.
  - If `io_rdy` arrives in the same cycle as the timeout, `io_rdy` wins.
- **Undefined:** no counter exists, REQ waits indefinitely, and `io_timeout_err` is tied 0.

## Test plan

- Store 16'h1234 to 0x0010, then load 0x0010 on the next instruction → `dm_rd_data_EX_DM`=16'h1234 the cycle after the load, `stall_DM` never asserted.
- Re and we together on 0x0020 (old 16'hAAAA, new 16'h5555) → read returns 16'hAAAA; a later load returns 16'h5555.
- Load from 0xC004 with `io_rdy` after 3 cycles and `io_rdata`=16'hBEEF:
  - `io_addr`=12'h004 and `io_re` high for 3 cycles;
  - `stall_DM` high for 3 cycles;
  - RESP output 16'hBEEF.
- Two back-to-back I/O writes with `io_rdy` immediate → each has 1 stall cycle, second REQ entered directly from RESP, `io_we` low for exactly the RESP cycle.
- `rst` asserted on the 2nd REQ cycle → next edge: IDLE, strobes 0, `stall_DM` 0; `io_rdy` pulsed afterwards has no effect.
- With DM_IO_TIMEOUT_EN and `IO_TIMEOUT`=4, `io_rdy` never asserted → stall 4 cycles, data 16'hDEAD, `io_timeout_err`=1 until `rst`.
